// File: rtl/clemens_nasenberg_top.sv
// -----------------------------------------------------------------------------
// clemens_nasenberg_top
//   Free-running decimal counter shown on a single 7-segment digit. The
//   displayed digit steps 0..9 (and wraps) once every PRESCALE clock edges.
//   The decimal point flips on every digit step, so it blinks at half the
//   digit rate.
//
// Parameters
//   PRESCALE    clock edges per digit step, 1..65536
//
// Ports
//   io_in[0]    clk, all state changes on the rising edge
//   io_in[1]    rst, synchronous active-low reset (0 = reset)
//   io_in[7:2]  unused, no effect on any state or output
//   io_out[6:0] segments {g,f,e,d,c,b,a}, active-high, a = bit 0
//   io_out[7]   decimal point, active-high
// -----------------------------------------------------------------------------
module clemens_nasenberg_top #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  // A 1-cycle prescaler still needs a 1-bit counter so the logic stays legal.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0]    DIG_MAX  = 4'd9;

  logic clk;
  logic rst;
  assign clk = io_in[0];
  assign rst = io_in[1];

  // The remaining pins are left unconnected on purpose.
  logic unused_io;
  assign unused_io = ^io_in[7:2];

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    dig_q,  dig_d;
  logic          dp_q,   dp_d;
  logic          step;

  // Next-state logic: the prescaler rolls over on its terminal count and
  // that rollover is the single event that advances the digit and the dot.
  always_comb begin
    step   = (pcnt_q == PCNT_MAX);
    pcnt_d = pcnt_q + PW'(1);
    dig_d  = dig_q;
    dp_d   = dp_q;
    if (step) begin
      pcnt_d = '0;
      dig_d  = (dig_q == DIG_MAX) ? 4'd0 : dig_q + 4'd1;
      dp_d   = ~dp_q;
    end
  end

  // Reset takes priority, so a reset mid-count drops any partial progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
      dig_q  <= 4'd0;
      dp_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      dig_q  <= dig_d;
      dp_q   <= dp_d;
    end
  end

  // Segment decode straight off the digit register, so the display follows
  // the register in the same cycle. Codes 10..15 cannot occur and blank.
  logic [6:0] seg;
  always_comb begin
    seg = 7'h00;
    unique case (dig_q)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign io_out = {dp_q, seg};

endmodule

// File: tb/tb_clemens_nasenberg_top.sv
// -----------------------------------------------------------------------------
// tb_clemens_nasenberg_top
//   Bench for the 7-segment decimal counter. Two instances share clock and
//   reset: one at PRESCALE=1000 and one at PRESCALE=1. A behavioural model
//   advances on every edge and pushes the expected io_out of both instances
//   into queues; each test pops them after the edge and compares.
// -----------------------------------------------------------------------------
module tb_clemens_nasenberg_top;

  localparam int P = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] unused = 6'd0;
  logic [7:0] io_in;
  logic [7:0] io_out0;
  logic [7:0] io_out1;
  bit         toggle_unused = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign io_in = {unused, rst_n, clk};

  clemens_nasenberg_top #(.PRESCALE(P)) dut0 (.io_in(io_in), .io_out(io_out0));
  clemens_nasenberg_top #(.PRESCALE(1)) dut1 (.io_in(io_in), .io_out(io_out1));

  // Reference model state
  int m_pcnt = 0;
  int m_dig  = 0;
  bit m_dp   = 1'b0;
  int m1_dig = 0;
  bit m1_dp  = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Advance the model by one edge, queue the expectations, then take the edge
  // and settle 1 time unit past it so outputs are sampled away from the edge.
  task automatic advance();
    if (toggle_unused) unused = 6'($urandom);
    if (!rst_n) begin
      m_pcnt = 0; m_dig = 0; m_dp = 1'b0;
      m1_dig = 0; m1_dp = 1'b0;
    end else begin
      if (m_pcnt == P - 1) begin
        m_pcnt = 0;
        m_dig  = (m_dig == 9) ? 0 : m_dig + 1;
        m_dp   = ~m_dp;
      end else begin
        m_pcnt = m_pcnt + 1;
      end
      m1_dig = (m1_dig == 9) ? 0 : m1_dig + 1;
      m1_dp  = ~m1_dp;
    end
    q0.push_back({m_dp, seg_of(m_dig)});
    q1.push_back({m1_dp, seg_of(m1_dig)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e0, e1;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (io_out0 !== e0 || io_out0 !== 8'h3F) begin
        errors++;
        $display("FAIL reset_p1000 edge %0d: io_out=%h expected 3f", i, io_out0);
      end
      checks++;
      if (io_out1 !== e1 || io_out1 !== 8'h3F) begin
        errors++;
        $display("FAIL reset_p1 edge %0d: io_out=%h expected 3f", i, io_out1);
      end
    end
  endtask

  // Release reset and check the first step lands exactly on edge P.
  task automatic test_step_timing();
    logic [7:0] e0, e1;
    rst_n = 1'b1;
    for (int i = 1; i <= P; i++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (io_out0 !== e0) begin
        errors++;
        $display("FAIL step_timing edge %0d: io_out=%h expected %h", i, io_out0, e0);
      end
      if (i == P - 1) begin
        checks++;
        if (io_out0 !== 8'h3F) begin
          errors++;
          $display("FAIL step_timing_hold: io_out=%h expected 3f", io_out0);
        end
      end
    end
    checks++;
    if (io_out0 !== 8'h86) begin
      errors++;
      $display("FAIL step_timing_first: io_out=%h expected 86", io_out0);
    end
  endtask

  // One full 0..9 cycle with the unused pins scrambled every edge.
  task automatic test_full_sequence();
    logic [7:0] e0, e1, cexp;
    int d;
    toggle_unused = 1'b1;
    for (int j = 1; j <= 10 * P; j++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (io_out0 !== e0) begin
        errors++;
        $display("FAIL full_seq edge %0d: io_out=%h expected %h", j, io_out0, e0);
      end
      if (j % P == 0) begin
        d    = (1 + j / P) % 10;
        cexp = {1'(d % 2), seg_of(d)};
        checks++;
        if (io_out0 !== cexp) begin
          errors++;
          $display("FAIL full_seq_step %0d: io_out=%h expected %h", j / P, io_out0, cexp);
        end
      end
    end
    toggle_unused = 1'b0;
    unused = 6'd0;
  endtask

  // Reach digit 4 with the prescaler at 500, reset, then re-time the step.
  task automatic test_reset_mid();
    logic [7:0] e0, e1;
    for (int i = 0; i < 3 * P + 500; i++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
    end
    checks++;
    if (io_out0 !== 8'h66) begin
      errors++;
      $display("FAIL reset_mid_pre: io_out=%h expected 66", io_out0);
    end
    rst_n = 1'b0;
    advance();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (io_out0 !== e0 || io_out0 !== 8'h3F) begin
      errors++;
      $display("FAIL reset_mid_clear: io_out=%h expected 3f", io_out0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= P; i++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (io_out0 !== e0) begin
        errors++;
        $display("FAIL reset_mid edge %0d: io_out=%h expected %h", i, io_out0, e0);
      end
    end
    checks++;
    if (io_out0 !== 8'h86) begin
      errors++;
      $display("FAIL reset_mid_step: io_out=%h expected 86", io_out0);
    end
  endtask

  // PRESCALE=1 instance: steps on every edge and wraps after ten.
  task automatic test_prescale1();
    logic [7:0] e0, e1, cexp;
    rst_n = 1'b0;
    advance();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (io_out1 !== e1) begin
      errors++;
      $display("FAIL p1_reset: io_out=%h expected %h", io_out1, e1);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      advance();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      cexp = {1'(i % 2), seg_of(i % 10)};
      checks++;
      if (io_out1 !== e1 || io_out1 !== cexp) begin
        errors++;
        $display("FAIL p1_step edge %0d: io_out=%h expected %h", i, io_out1, cexp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_timing();
    test_full_sequence();
    test_reset_mid();
    test_prescale1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
